hazard_scoreboard: RTL

Parametrised register-hazard scoreboard for the pipelined MIPS datapath. It replaces the fixed EX/MEM forwarding decode with a shadow pipeline of in-flight destination tags, DEPTH stages deep. It produces a decode-stage load-use stall and registered forwarding selects for the EX stage. A saturating stall counter is included for performance measurement.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/sb_lookup.sv | 50 +++++
 rtl/hazard_scoreboard.sv | 90 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the register-hazard scoreboard.
package hazard_pkg;

  // Widest register tag an entry can hold; the top zero-extends into it.
  localparam int SB_TAG_W = 8;

  // Operand select value meaning "use the ID/EX register-file data".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [SB_TAG_W-1:0] dest;
    logic                load;
  } sb_entry_t;

  // Width of an operand select for a shadow pipeline of the given depth.
  function automatic int sel_width(input int depth);
    return (depth < 3) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sb_lookup.sv
// Priority match of one source operand against the in-flight destination tags.
// Entry 0 is stage 1 (EX); the youngest matching producer decides the result.
module sb_lookup
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int RW       = 5,
  parameter int SELW     = sel_width(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic                  use_src,
  input  logic [RW-1:0]         src,
  output logic                  hit,
  output logic [SELW-1:0]       sel,
  output logic                  hazard
);

  logic [SB_TAG_W-1:0] tag;

  assign tag = SB_TAG_W'(src);

  // Youngest producer wins; a WB-stage match reads the already-written file.
  always_comb begin
    logic found;
    logic found_load;
    int   found_k;
    found      = 1'b0;
    found_load = 1'b0;
    found_k    = 0;
    hit        = 1'b0;
    sel        = SELW'(FWD_RF);
    hazard     = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && entries[k].valid && entries[k].dest == tag) begin
        found      = 1'b1;
        found_k    = k;
        found_load = entries[k].load;
      end
    end
    if (use_src && src != '0 && found) begin
      hit = 1'b1;
      if (found_k + 1 < DEPTH) begin
        if (found_load && found_k + 1 < LOAD_LAT) hazard = 1'b1;
        else                                      sel    = SELW'(found_k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadow pipeline of in-flight destination tags producing the decode load-use
// stall, registered EX forwarding selects and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NREG     = 32,
  parameter  int RW       = $clog2(NREG),
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 2,
  parameter  int CNTW     = 16,
  localparam int SELW     = sel_width(DEPTH)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            advance,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_wen,
  input  logic [RW-1:0]   id_dest,
  input  logic            id_load,
  output logic            stall,
  output logic [SELW-1:0] ex_fwd_a,
  output logic [SELW-1:0] ex_fwd_b,
  output logic [CNTW-1:0] stall_cnt
);

  sb_entry_t [DEPTH-1:0] entries;

  logic            hit_a, hit_b, haz_a, haz_b;
  logic [SELW-1:0] sel_a, sel_b;
  logic            issue, push;

  sb_lookup #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .RW(RW), .SELW(SELW)) u_lookup_a (
    .entries (entries),
    .use_src (id_use_rs),
    .src     (id_rs),
    .hit     (hit_a),
    .sel     (sel_a),
    .hazard  (haz_a)
  );

  sb_lookup #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .RW(RW), .SELW(SELW)) u_lookup_b (
    .entries (entries),
    .use_src (id_use_rt),
    .src     (id_rt),
    .hit     (hit_b),
    .sel     (sel_b),
    .hazard  (haz_b)
  );

  // Flush outranks stall; only an issued writer of a non-zero register enters.
  always_comb begin
    stall = id_valid && !flush && ((hit_a && haz_a) || (hit_b && haz_b));
    issue = id_valid && !flush && !stall;
    push  = issue && id_wen && (id_dest != '0);
  end

  // Shadow pipeline: age every entry, insert the decode tag or a bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      entries <= '0;
    end else if (advance) begin
      for (int k = DEPTH - 1; k > 0; k--) entries[k] <= entries[k-1];
      entries[0] <= push ? '{valid: 1'b1, dest: SB_TAG_W'(id_dest), load: id_load}
                         : '0;
    end
  end

  // Forwarding selects follow the issued instruction into EX.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_fwd_a <= SELW'(FWD_RF);
      ex_fwd_b <= SELW'(FWD_RF);
    end else if (advance) begin
      ex_fwd_a <= issue ? sel_a : SELW'(FWD_RF);
      ex_fwd_b <= issue ? sel_b : SELW'(FWD_RF);
    end
  end

  // Count stall cycles that actually cost an advance, saturating at all-ones.
  always_ff @(posedge CLK) begin
    if (RST)                                      stall_cnt <= '0;
    else if (advance && stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
